// File: rtl/rv32v_types_pkg.sv
// Shared types for the rv32v vector register file: element widths,
// register selector and the byte-size helper.
package rv32v_types_pkg;

  localparam int NUM_LANES_DEF = 2;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2
  } sew_t;

  typedef logic [4:0] vreg_sel_t;

  // Bytes per element; the unused encoding is treated as 32-bit
  function automatic logic [2:0] sew_bytes(sew_t s);
    case (s)
      SEW8:    return 3'd1;
      SEW16:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rv32v_vreg_lane_extract.sv
// One lane of a read port: pick sew bytes starting at byte_addr within a
// register row (wrapping inside the row) and zero-extend to 32 bits.
module rv32v_vreg_lane_extract
  import rv32v_types_pkg::*;
#(
  parameter int VLEN     = 128,
  parameter int VL_WIDTH = $clog2(VLEN/8)
) (
  input  logic [VLEN-1:0]     row,
  input  logic [VL_WIDTH-1:0] byte_addr,
  input  sew_t                sew,
  output logic [31:0]         elem
);

  logic [VL_WIDTH-1:0] bi;

  // Gather up to four bytes; the VL_WIDTH-bit index wraps modulo row size
  always_comb begin
    elem = '0;
    bi   = '0;
    for (int b = 0; b < 4; b++) begin
      bi = byte_addr + VL_WIDTH'(b);
      if (3'(b) < sew_bytes(sew))
        elem[8*b +: 8] = row[{bi, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/rv32v_banked_vreg_file.sv
// 32 x VLEN vector register file: NUM_READ_PORTS registered element-group
// read ports with same-cycle write bypass, one lane-masked write port with
// vl tail suppression and mask-bit mode, and a post-reset clear sequencer.
module rv32v_banked_vreg_file
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES      = NUM_LANES_DEF,
  parameter int VLEN           = 128,
  parameter int NUM_READ_PORTS = 3,
  parameter int VL_WIDTH       = $clog2(VLEN/8)
) (
  input  logic                                         CLK,
  input  logic                                         RST,
  output logic                                         ready,
  input  vreg_sel_t [NUM_READ_PORTS-1:0]               rd_sel,
  input  logic [NUM_READ_PORTS-1:0][VL_WIDTH-1:0]      rd_offset,
  input  sew_t [NUM_READ_PORTS-1:0]                    rd_sew,
  output logic [NUM_READ_PORTS-1:0][NUM_LANES-1:0][31:0] rd_data,
  output logic [NUM_READ_PORTS-1:0][NUM_LANES-1:0]     rd_mask,
  input  logic [VL_WIDTH:0]                            vl,
  input  logic [NUM_LANES-1:0]                         wen,
  input  vreg_sel_t                                    w_vd,
  input  logic [VL_WIDTH-1:0]                          w_offset,
  input  sew_t                                         w_eew,
  input  logic [NUM_LANES-1:0][31:0]                   w_data,
  input  logic                                         single_bit_write
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                             state;
  logic [4:0]                         clear_ptr;
  logic [VLEN-1:0]                    regs [32];
  logic [VLEN-1:0]                    wrow;
  logic [VLEN-1:0]                    v0row;
  logic [VLEN-1:0]                    rrow [NUM_READ_PORTS];
  logic [NUM_LANES-1:0][VL_WIDTH:0]   w_e;
  logic [NUM_LANES-1:0][VL_WIDTH-1:0] w_ba;
  logic [VL_WIDTH-1:0]                wbi;
  logic [NUM_READ_PORTS-1:0][NUM_LANES-1:0][31:0] rd_next;
  logic [NUM_READ_PORTS-1:0][NUM_LANES-1:0]       mask_next;

  // Byte address of element e inside its register, wrapped to the row
  function automatic logic [VL_WIDTH-1:0] byte_addr(logic [VL_WIDTH:0] e, sew_t s);
    logic [VL_WIDTH:0] p;
    p = e * (VL_WIDTH+1)'(sew_bytes(s));
    return p[VL_WIDTH-1:0];
  endfunction

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_wlane
    assign w_e[l]  = (VL_WIDTH+1)'(w_offset) + (VL_WIDTH+1)'(l);
    assign w_ba[l] = byte_addr(w_e[l], w_eew);
  end

  // Post-write image of w_vd; ascending lane order lets the highest lane win
  always_comb begin
    wrow = regs[w_vd];
    wbi  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (wen[l] && (w_e[l] < vl)) begin
        if (single_bit_write) begin
          wrow[w_e[l]] = w_data[l][0];
        end else begin
          for (int b = 0; b < 4; b++) begin
            wbi = w_ba[l] + VL_WIDTH'(b);
            if (3'(b) < sew_bytes(w_eew))
              wrow[{wbi, 3'b000} +: 8] = w_data[l][8*b +: 8];
          end
        end
      end
    end
  end

  // Read rows see this cycle's write (bypass), including v0 for masks
  assign v0row = (state == READY && w_vd == '0) ? wrow : regs[0];

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    assign rrow[p] = (state == READY && rd_sel[p] == w_vd) ? wrow : regs[rd_sel[p]];
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [VL_WIDTH:0]   e;
      logic [VL_WIDTH-1:0] ba;
      logic [31:0]         ext;
      assign e  = (VL_WIDTH+1)'(rd_offset[p]) + (VL_WIDTH+1)'(l);
      assign ba = byte_addr(e, rd_sew[p]);
      rv32v_vreg_lane_extract #(.VLEN(VLEN), .VL_WIDTH(VL_WIDTH)) u_ext (
        .row       (rrow[p]),
        .byte_addr (ba),
        .sew       (rd_sew[p]),
        .elem      (ext)
      );
      assign rd_next[p][l]   = (e < vl) ? ext : 32'd0;
      assign mask_next[p][l] = v0row[e];
    end
  end

  // Clear sequencer and array update; writes only land once READY
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= CLEAR;
      clear_ptr <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          regs[clear_ptr] <= '0;
          clear_ptr       <= clear_ptr + 5'd1;
          if (clear_ptr == 5'd31) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        default: regs[w_vd] <= wrow;
      endcase
    end
  end

  // Registered read outputs; forced to zero while clearing
  always_ff @(posedge CLK) begin
    if (RST || state != READY) begin
      rd_data <= '0;
      rd_mask <= '0;
    end else begin
      rd_data <= rd_next;
      rd_mask <= mask_next;
    end
  end

endmodule

// File: tb/tb_rv32v_banked_vreg_file.sv
// Directed bench for rv32v_banked_vreg_file at default parameters.
module tb_rv32v_banked_vreg_file;
  import rv32v_types_pkg::*;

  logic                   CLK;
  logic                   RST;
  logic                   ready;
  vreg_sel_t [2:0]        rd_sel;
  logic [2:0][3:0]        rd_offset;
  sew_t [2:0]             rd_sew;
  logic [2:0][1:0][31:0]  rd_data;
  logic [2:0][1:0]        rd_mask;
  logic [4:0]             vl;
  logic [1:0]             wen;
  vreg_sel_t              w_vd;
  logic [3:0]             w_offset;
  sew_t                   w_eew;
  logic [1:0][31:0]       w_data;
  logic                   single_bit_write;

  int pass_cnt = 0;
  int total    = 0;

  rv32v_banked_vreg_file #(.NUM_LANES(2), .VLEN(128), .NUM_READ_PORTS(3)) dut (
    .CLK(CLK), .RST(RST), .ready(ready),
    .rd_sel(rd_sel), .rd_offset(rd_offset), .rd_sew(rd_sew),
    .rd_data(rd_data), .rd_mask(rd_mask), .vl(vl),
    .wen(wen), .w_vd(w_vd), .w_offset(w_offset), .w_eew(w_eew),
    .w_data(w_data), .single_bit_write(single_bit_write)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [4:0] sel, input logic [3:0] off, input sew_t s);
    rd_sel[p]    = sel;
    rd_offset[p] = off;
    rd_sew[p]    = s;
  endtask

  task automatic set_wr(input logic [4:0] vd, input logic [3:0] off, input sew_t s,
                        input logic [1:0] en, input logic [31:0] d0, input logic [31:0] d1);
    w_vd      = vd;
    w_offset  = off;
    w_eew     = s;
    wen       = en;
    w_data[0] = d0;
    w_data[1] = d1;
  endtask

  task automatic test_reset_clear();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int p = 0; p < 3; p++) set_rd(p, 5'd5, 4'd0, SEW32);
    total++;
    if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready);
    else pass_cnt++;
    for (int k = 1; k <= 32; k++) begin
      if (k == 3) set_wr(5'd1, 4'd0, SEW8, 2'b11, 32'h55, 32'h66);
      tick();
      wen = 2'b00;
      total++;
      if (ready !== (k == 32)) $display("FAIL clear_ready k=%0d: got %b expected %b", k, ready, (k == 32));
      else pass_cnt++;
      total++;
      if (rd_data[0][0] !== 32'd0) $display("FAIL clear_read k=%0d: got %h expected 0", k, rd_data[0][0]);
      else pass_cnt++;
    end
    set_rd(0, 5'd1, 4'd0, SEW8);
    tick();
    total++;
    if (rd_data[0] !== 64'd0) $display("FAIL write_in_clear: got %h expected 0", rd_data[0]);
    else pass_cnt++;
  endtask

  task automatic test_sew8_cross();
    vl = 5'd16;
    set_wr(5'd3, 4'd0, SEW8, 2'b11, 32'hAB, 32'hCD);
    tick();
    wen = 2'b00;
    set_rd(0, 5'd3, 4'd0, SEW16);
    set_rd(1, 5'd3, 4'd1, SEW8);
    tick();
    total++;
    if (rd_data[0][0] !== 32'h0000CDAB) $display("FAIL sew16_lane0: got %h expected 0000cdab", rd_data[0][0]);
    else pass_cnt++;
    total++;
    if (rd_data[0][1] !== 32'h0) $display("FAIL sew16_lane1: got %h expected 0", rd_data[0][1]);
    else pass_cnt++;
    total++;
    if (rd_data[1][0] !== 32'hCD) $display("FAIL sew8_off1_lane0: got %h expected cd", rd_data[1][0]);
    else pass_cnt++;
    total++;
    if (rd_data[1][1] !== 32'h0) $display("FAIL sew8_off1_lane1: got %h expected 0", rd_data[1][1]);
    else pass_cnt++;
  endtask

  task automatic test_tail();
    vl = 5'd1;
    set_wr(5'd4, 4'd0, SEW32, 2'b11, 32'h11111111, 32'h22222222);
    tick();
    wen = 2'b00;
    set_rd(0, 5'd4, 4'd0, SEW32);
    tick();
    total++;
    if (rd_data[0] !== {32'h0, 32'h11111111}) $display("FAIL tail_read_vl1: got %h expected 0000000011111111", rd_data[0]);
    else pass_cnt++;
    vl = 5'd0;
    set_wr(5'd4, 4'd0, SEW8, 2'b01, 32'h99, 32'h0);
    tick();
    wen = 2'b00;
    vl = 5'd16;
    tick();
    total++;
    if (rd_data[0] !== {32'h0, 32'h11111111}) $display("FAIL tail_suppressed: got %h expected 0000000011111111", rd_data[0]);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    vl = 5'd16;
    set_wr(5'd7, 4'd0, SEW32, 2'b01, 32'hDEADBEEF, 32'h0);
    for (int p = 0; p < 3; p++) set_rd(p, 5'd7, 4'd0, SEW32);
    tick();
    wen = 2'b00;
    for (int p = 0; p < 3; p++) begin
      total++;
      if (rd_data[p] !== {32'h0, 32'hDEADBEEF}) $display("FAIL bypass_port%0d: got %h expected 00000000deadbeef", p, rd_data[p]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mask();
    vl = 5'd16;
    single_bit_write = 1'b1;
    set_wr(5'd0, 4'd5, SEW32, 2'b01, 32'h1, 32'h0);
    set_rd(0, 5'd0, 4'd5, SEW8);
    set_rd(1, 5'd0, 4'd4, SEW8);
    set_rd(2, 5'd0, 4'd0, SEW8);
    tick();
    single_bit_write = 1'b0;
    wen = 2'b00;
    total++;
    if (rd_mask[0] !== 2'b01) $display("FAIL mask_bits56: got %b expected 01", rd_mask[0]);
    else pass_cnt++;
    total++;
    if (rd_mask[1] !== 2'b10) $display("FAIL mask_bits45: got %b expected 10", rd_mask[1]);
    else pass_cnt++;
    total++;
    if (rd_data[2][0] !== 32'h20) $display("FAIL mask_v0_byte0: got %h expected 20", rd_data[2][0]);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    vl = 5'd16;
    set_wr(5'd8, 4'd5, SEW32, 2'b01, 32'hCAFEF00D, 32'h0);
    tick();
    wen = 2'b00;
    set_rd(0, 5'd8, 4'd1, SEW32);
    set_rd(1, 5'd9, 4'd1, SEW32);
    tick();
    total++;
    if (rd_data[0][0] !== 32'hCAFEF00D) $display("FAIL wrap_elem: got %h expected cafef00d", rd_data[0][0]);
    else pass_cnt++;
    total++;
    if (rd_data[1] !== 64'd0) $display("FAIL wrap_no_carry: got %h expected 0", rd_data[1]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    vl = 5'd16;
    set_wr(5'd10, 4'd0, SEW32, 2'b01, 32'h1, 32'h0);
    tick();
    set_wr(5'd10, 4'd0, SEW32, 2'b01, 32'h2, 32'h0);
    set_rd(0, 5'd10, 4'd0, SEW32);
    tick();
    wen = 2'b00;
    total++;
    if (rd_data[0][0] !== 32'h2) $display("FAIL b2b_bypass: got %h expected 2", rd_data[0][0]);
    else pass_cnt++;
    set_wr(5'd11, 4'd0, SEW16, 2'b11, 32'hFFFF_AAAA, 32'hFFFF_BBBB);
    set_rd(1, 5'd11, 4'd0, SEW32);
    tick();
    wen = 2'b00;
    total++;
    if (rd_data[0][0] !== 32'h2) $display("FAIL b2b_hold: got %h expected 2", rd_data[0][0]);
    else pass_cnt++;
    total++;
    if (rd_data[1][0] !== 32'hBBBBAAAA) $display("FAIL b2b_sew16_pack: got %h expected bbbbaaaa", rd_data[1][0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_restart();
    int cnt;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    total++;
    if (ready !== 1'b0) $display("FAIL restart_ready: got %b expected 0", ready);
    else pass_cnt++;
    cnt = 0;
    while (!ready && cnt < 40) begin
      tick();
      cnt++;
    end
    total++;
    if (cnt !== 32) $display("FAIL restart_cycles: got %0d expected 32", cnt);
    else pass_cnt++;
    set_rd(0, 5'd7, 4'd0, SEW32);
    tick();
    total++;
    if (rd_data[0] !== 64'd0) $display("FAIL restart_cleared: got %h expected 0", rd_data[0]);
    else pass_cnt++;
  endtask

  initial begin
    RST = 1'b1;
    rd_sel = '0;
    rd_offset = '0;
    rd_sew = {SEW8, SEW8, SEW8};
    vl = 5'd16;
    wen = '0;
    w_vd = '0;
    w_offset = '0;
    w_eew = SEW8;
    w_data = '0;
    single_bit_write = 1'b0;
    test_reset_clear();
    test_sew8_cross();
    test_tail();
    test_bypass();
    test_mask();
    test_wrap();
    test_back_to_back();
    test_reset_restart();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
